// File: rtl/wb_pia_arb_if.sv
// Bus bundle for wb_pia_arb: the CPU requester (m0), the host/debug
// requester (m1), the shared PIA slave port (s_*) and the grant indicator.
interface wb_pia_arb_if #(
  parameter int ADR_W = 7,
  parameter int DAT_W = 8
);
  logic             m0_stb_i;
  logic             m0_we_i;
  logic [ADR_W-1:0] m0_adr_i;
  logic [DAT_W-1:0] m0_dat_i;
  logic             m0_ack_o;
  logic             m0_err_o;
  logic [DAT_W-1:0] m0_dat_o;

  logic             m1_stb_i;
  logic             m1_we_i;
  logic [ADR_W-1:0] m1_adr_i;
  logic [DAT_W-1:0] m1_dat_i;
  logic             m1_ack_o;
  logic             m1_err_o;
  logic [DAT_W-1:0] m1_dat_o;

  logic             s_stb_o;
  logic             s_we_o;
  logic [ADR_W-1:0] s_adr_o;
  logic [DAT_W-1:0] s_dat_o;
  logic             s_ack_i;
  logic [DAT_W-1:0] s_dat_i;

  logic [1:0]       grant_o;

  // Arbiter side: answers both requesters and masters the PIA slave port.
  modport master (
    input  m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i,
    output m0_ack_o, m0_err_o, m0_dat_o,
    input  m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i,
    output m1_ack_o, m1_err_o, m1_dat_o,
    output s_stb_o, s_we_o, s_adr_o, s_dat_o,
    input  s_ack_i, s_dat_i,
    output grant_o
  );

  // Environment side: the two requesters and the PIA itself.
  modport slave (
    output m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i,
    input  m0_ack_o, m0_err_o, m0_dat_o,
    output m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i,
    input  m1_ack_o, m1_err_o, m1_dat_o,
    input  s_stb_o, s_we_o, s_adr_o, s_dat_o,
    output s_ack_i, s_dat_i,
    input  grant_o
  );
endinterface

// File: rtl/wb_pia_arb.sv
// wb_pia_arb: two-master round-robin Wishbone arbiter in front of the PIA.
// One transaction per grant, registered slave request, watchdog error.
// Optional macro PIA_ARB_LOCK_EN adds m1_lock_i, letting the host keep the
// bus across back-to-back transactions (atomic timer programming).
module wb_pia_arb #(
  parameter int ADR_W   = 7,
  parameter int DAT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
`ifdef PIA_ARB_LOCK_EN
  input  logic m1_lock_i,
`endif
  wb_pia_arb_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Counter value on which a still-unacknowledged cycle is abandoned.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t           state_reg, state_next;
  logic             last_reg, last_next;   // index of the last granted master = current owner
  logic [7:0]       cnt_reg, cnt_next;
  logic             s_stb_reg, s_stb_next;
  logic             s_we_reg, s_we_next;
  logic [ADR_W-1:0] s_adr_reg, s_adr_next;
  logic [DAT_W-1:0] s_dat_reg, s_dat_next;
  logic [1:0]       grant_reg, grant_next;
  logic             pick;                  // master chosen in IDLE
  logic             fin_ack;               // owner's cycle ends with an ack this edge
  logic             fin_err;               // owner's cycle ends with a timeout this edge

  logic             ack_reg [2];
  logic             err_reg [2];
  logic [DAT_W-1:0] dat_reg [2];

`ifdef PIA_ARB_LOCK_EN
  logic             lock_reg, lock_next;
`endif

  // Next-state, arbitration and slave-request decode.
  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    cnt_next   = cnt_reg;
    s_stb_next = s_stb_reg;
    s_we_next  = s_we_reg;
    s_adr_next = s_adr_reg;
    s_dat_next = s_dat_reg;
    grant_next = grant_reg;
    pick       = 1'b0;
    fin_ack    = 1'b0;
    fin_err    = 1'b0;
`ifdef PIA_ARB_LOCK_EN
    lock_next  = lock_reg;
`endif
    case (state_reg)
      IDLE: begin
        // A lone requester wins; on a tie the master not served last wins.
        pick = bus.m1_stb_i && (!bus.m0_stb_i || !last_reg);
`ifdef PIA_ARB_LOCK_EN
        // A held lock keeps m1 on the bus while it asks for it and keeps
        // requesting; otherwise the lock falls away and round-robin resumes.
        if (lock_reg) begin
          if (m1_lock_i && bus.m1_stb_i) begin
            pick = 1'b1;
          end else begin
            lock_next = 1'b0;
          end
        end
`endif
        if (bus.m0_stb_i || bus.m1_stb_i) begin
          state_next = BUSY;
          s_stb_next = 1'b1;
          s_we_next  = pick ? bus.m1_we_i  : bus.m0_we_i;
          s_adr_next = pick ? bus.m1_adr_i : bus.m0_adr_i;
          s_dat_next = pick ? bus.m1_dat_i : bus.m0_dat_i;
          grant_next = pick ? 2'b10 : 2'b01;
          last_next  = pick;
          cnt_next   = '0;
        end
      end
      BUSY: begin
        // Ack beats a timeout landing on the same edge.
        if (bus.s_ack_i) begin
          fin_ack    = 1'b1;
          s_stb_next = 1'b0;
          state_next = RELEASE;
        end else if (cnt_reg == CNT_LAST) begin
          fin_err    = 1'b1;
          s_stb_next = 1'b0;
          state_next = RELEASE;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      RELEASE: begin
        // One dead cycle swallows the owner's lingering stb and the
        // slave's trailing registered ack.
        state_next = IDLE;
        grant_next = 2'b00;
`ifdef PIA_ARB_LOCK_EN
        if (last_reg && m1_lock_i) begin
          lock_next = 1'b1;
        end
`endif
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Arbiter state and registered slave-side request.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      last_reg  <= 1'b1;
      cnt_reg   <= '0;
      s_stb_reg <= 1'b0;
      s_we_reg  <= 1'b0;
      s_adr_reg <= '0;
      s_dat_reg <= '0;
      grant_reg <= 2'b00;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
      s_stb_reg <= s_stb_next;
      s_we_reg  <= s_we_next;
      s_adr_reg <= s_adr_next;
      s_dat_reg <= s_dat_next;
      grant_reg <= grant_next;
    end
  end

`ifdef PIA_ARB_LOCK_EN
  // Host bus lock, held across m1 transactions.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lock_reg <= 1'b0;
    end else begin
      lock_reg <= lock_next;
    end
  end
`endif

  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    // Per-master ack/err pulses and read-data capture, owner only.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        ack_reg[gi] <= 1'b0;
        err_reg[gi] <= 1'b0;
        dat_reg[gi] <= '0;
      end else begin
        ack_reg[gi] <= fin_ack && (last_reg == 1'(gi));
        err_reg[gi] <= fin_err && (last_reg == 1'(gi));
        if (fin_ack && !s_we_reg && (last_reg == 1'(gi))) begin
          dat_reg[gi] <= bus.s_dat_i;
        end
      end
    end
  end

  assign bus.m0_ack_o = ack_reg[0];
  assign bus.m0_err_o = err_reg[0];
  assign bus.m0_dat_o = dat_reg[0];
  assign bus.m1_ack_o = ack_reg[1];
  assign bus.m1_err_o = err_reg[1];
  assign bus.m1_dat_o = dat_reg[1];
  assign bus.s_stb_o  = s_stb_reg;
  assign bus.s_we_o   = s_we_reg;
  assign bus.s_adr_o  = s_adr_reg;
  assign bus.s_dat_o  = s_dat_reg;
  assign bus.grant_o  = grant_reg;

endmodule
